// File: rtl/cache_refill_ctrl.sv
// Miss-handling refill controller: issues one line-aligned burst read per miss,
// writes each returned beat into the data bank, forwards the critical word and installs the tag.
module cache_refill_ctrl #(
  parameter int BYTES_PER_LINE = 16,
  parameter int NUM_LINE       = 256,
  parameter int OFFSET_WIDTH   = $clog2(BYTES_PER_LINE),
  parameter int INDEX_WIDTH    = $clog2(NUM_LINE),
  parameter int TAG_WIDTH      = 32 - OFFSET_WIDTH - INDEX_WIDTH,
  parameter int WORDS_PER_LINE = BYTES_PER_LINE / 4,
  parameter int WORD_SEL_WIDTH = $clog2(WORDS_PER_LINE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      miss_valid,
  output logic                      miss_ready,
  input  logic [TAG_WIDTH-1:0]      miss_tag,
  input  logic [INDEX_WIDTH-1:0]    miss_index,
  input  logic [OFFSET_WIDTH-1:0]   miss_offset,
  output logic                      rd_req,
  output logic [31:0]               rd_addr,
  input  logic                      rd_addr_ok,
  input  logic                      ret_valid,
  input  logic                      ret_last,
  input  logic [31:0]               ret_data,
  output logic                      data_we,
  output logic [INDEX_WIDTH-1:0]    data_index,
  output logic [WORD_SEL_WIDTH-1:0] data_word,
  output logic [31:0]               data_wdata,
  output logic                      tag_we,
  output logic [TAG_WIDTH-1:0]      tag_wdata,
  output logic                      crit_valid,
  output logic [31:0]               crit_data,
  output logic                      refill_done,
  output logic                      proto_err
);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_e;

  localparam logic [WORD_SEL_WIDTH-1:0] LAST_WORD = WORD_SEL_WIDTH'(WORDS_PER_LINE - 1);

  state_e                    state_q;
  logic [TAG_WIDTH-1:0]      tag_q;
  logic [INDEX_WIDTH-1:0]    index_q;
  logic [WORD_SEL_WIDTH-1:0] crit_sel_q;
  logic [WORD_SEL_WIDTH-1:0] cnt_q;
  logic                      crit_done_q;
  logic                      proto_err_q;
  logic                      beat;

  // Shifting the whole offset drops the byte-in-word bits to leave the word select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      index_q     <= '0;
      crit_sel_q  <= '0;
      cnt_q       <= '0;
      crit_done_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid) begin
            tag_q       <= miss_tag;
            index_q     <= miss_index;
            crit_sel_q  <= WORD_SEL_WIDTH'(miss_offset >> 2);
            cnt_q       <= '0;
            crit_done_q <= 1'b0;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (rd_addr_ok) state_q <= RECV;
        end
        RECV: begin
          if (ret_valid) begin
            cnt_q <= cnt_q + WORD_SEL_WIDTH'(1);
            if (cnt_q == crit_sel_q) crit_done_q <= 1'b1;
            if (ret_last) begin
              state_q <= DONE;
              if (cnt_q != LAST_WORD) proto_err_q <= 1'b1;
            end else if (cnt_q == LAST_WORD) begin
              proto_err_q <= 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write strobes are masked by reset so an abort suppresses the beat arriving alongside it.
  assign beat        = (state_q == RECV) && ret_valid && !reset;
  assign miss_ready  = (state_q == IDLE);
  assign rd_req      = (state_q == REQ);
  assign rd_addr     = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
  assign data_we     = beat;
  assign data_index  = index_q;
  assign data_word   = cnt_q;
  assign data_wdata  = ret_data;
  assign crit_valid  = beat && (cnt_q == crit_sel_q) && !crit_done_q;
  assign crit_data   = ret_data;
  assign tag_we      = (state_q == DONE) && !reset;
  assign tag_wdata   = tag_q;
  assign refill_done = (state_q == DONE) && !reset;
  assign proto_err   = proto_err_q;

endmodule
